// File: rtl/csa_add_sequencer.sv
// Multi-precision adder: walks WORDS 16-bit slices through one carry-select adder, LSW first.
// Optional: define CSA_SEQ_OVF_EN to add the signed-overflow output ovf.

module csa_ripple4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_carry;

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[4];
endmodule

// Four 4-bit blocks, each precomputed for carry-in 0 and 1; the real carry only drives muxes.
module carry_select_adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [3:0] w_sum0 [4];
    logic [3:0] w_sum1 [4];
    logic [3:0] w_cout0;
    logic [3:0] w_cout1;
    logic [4:0] w_carry;

    for (genvar g = 0; g < 4; g++) begin : g_block
        csa_ripple4 u_ripple0 (
            .i_a   (i_a[4*g +: 4]),
            .i_b   (i_b[4*g +: 4]),
            .i_cin (1'b0),
            .o_sum (w_sum0[g]),
            .o_cout(w_cout0[g])
        );
        csa_ripple4 u_ripple1 (
            .i_a   (i_a[4*g +: 4]),
            .i_b   (i_b[4*g +: 4]),
            .i_cin (1'b1),
            .o_sum (w_sum1[g]),
            .o_cout(w_cout1[g])
        );
    end

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int k = 0; k < 4; k++) begin
            o_sum[4*k +: 4] = w_carry[k] ? w_sum1[k] : w_sum0[k];
            w_carry[k + 1]  = w_cout0[k] | (w_cout1[k] & w_carry[k]);
        end
    end

    assign o_cout = w_carry[4];
endmodule

module csa_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 busy
`ifdef CSA_SEQ_OVF_EN
    ,output logic                ovf
`endif
);
    localparam int N     = 16 * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_busy;

    logic [15:0]      w_sliceA;
    logic [15:0]      w_sliceB;
    logic [15:0]      w_sliceSum;
    logic             w_sliceCout;

    assign w_sliceA = r_a[16*r_cnt +: 16];
    assign w_sliceB = r_b[16*r_cnt +: 16];

    carry_select_adder_16bit u_adder (
        .i_a   (w_sliceA),
        .i_b   (w_sliceB),
        .i_cin (r_carry),
        .o_sum (w_sliceSum),
        .o_cout(w_sliceCout)
    );

`ifdef CSA_SEQ_OVF_EN
    logic r_ovf;
    logic w_msbCarryIn;

    // Carry into bit 15 is recovered from the sum bit instead of tapping the adder internals.
    assign w_msbCarryIn = w_sliceA[15] ^ w_sliceB[15] ^ w_sliceSum[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_cnt == LAST_SLICE) begin
            r_ovf <= w_msbCarryIn ^ w_sliceCout;
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_carry   <= cin;
                        r_cnt     <= '0;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_sum[16*r_cnt +: 16] <= w_sliceSum;
                    r_carry               <= w_sliceCout;
                    // Counter parks at zero instead of wrapping past the last slice.
                    if (r_cnt == LAST_SLICE) begin
                        r_cout     <= w_sliceCout;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_csa_add_sequencer.sv
// Bench for csa_add_sequencer: arithmetic/handshake model checked every negedge plus directed literals.
// Honours CSA_SEQ_OVF_EN to exercise the ovf port.

module tb_csa_add_sequencer;
    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CSA_SEQ_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    csa_add_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
`ifdef CSA_SEQ_OVF_EN
        .ovf      (ovf),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model: exact arithmetic for the result, cycle counts for the handshake.
    int           mRun = 0;
    bit           mHold = 1'b0;
    logic [N-1:0] mSum = '0, pSum = '0;
    logic         mCout = 1'b0, pCout = 1'b0;
    logic         mOvf = 1'b0, pOvf = 1'b0;

    always @(negedge clk) begin
        logic [N:0]        fullSum;
        logic signed [N:0] signedSum;
        if (!rst_n) begin
            checkOutput("rst in_ready", in_ready, 1);
            checkOutput("rst out_valid", out_valid, 0);
            checkOutput("rst busy", busy, 0);
            checkOutput("rst sum", sum, 0);
            checkOutput("rst cout", cout, 0);
`ifdef CSA_SEQ_OVF_EN
            checkOutput("rst ovf", ovf, 0);
`endif
            mRun = 0; mHold = 1'b0; mSum = '0; mCout = 1'b0; mOvf = 1'b0;
        end else begin
            checkOutput("model in_ready", in_ready, (mRun == 0 && !mHold) ? 1 : 0);
            checkOutput("model busy", busy, (mRun != 0) ? 1 : 0);
            checkOutput("model out_valid", out_valid, mHold ? 1 : 0);
            if (mRun == 0) begin
                checkOutput("model sum", sum, mSum);
                checkOutput("model cout", cout, mCout);
`ifdef CSA_SEQ_OVF_EN
                checkOutput("model ovf", ovf, mOvf);
`endif
            end
            if (mHold) begin
                if (out_ready) mHold = 1'b0;
            end else if (mRun > 0) begin
                mRun--;
                if (mRun == 0) begin
                    mHold = 1'b1; mSum = pSum; mCout = pCout; mOvf = pOvf;
                end
            end else if (in_valid) begin
                fullSum   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                signedSum = $signed({a[N-1], a}) + $signed({b[N-1], b}) + $signed({{N{1'b0}}, cin});
                pSum  = fullSum[N-1:0];
                pCout = fullSum[N];
                pOvf  = signedSum[N] ^ signedSum[N-1];
                mRun  = WORDS;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
        int waited = 0;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output int busyCnt);
        lat = 0; busyCnt = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("out_valid timeout", out_valid, 1);
    endtask

    task automatic collectResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("post-handshake out_valid", out_valid, 0);
        checkOutput("post-handshake in_ready", in_ready, 1);
    endtask

    initial begin
        int lat, busyCnt;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset sum", sum, 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones + 0 + 1 wraps to zero with carry out.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        waitResult(lat, busyCnt);
        checkOutput("wrap latency", lat, WORDS);
        checkOutput("wrap sum", sum, 64'd0);
        checkOutput("wrap cout", cout, 1);
`ifdef CSA_SEQ_OVF_EN
        checkOutput("wrap ovf", ovf, 0);
`endif
        collectResult();

        applyStimulus(64'd999, 64'd14, 1'b1);
        waitResult(lat, busyCnt);
        checkOutput("small busy cycles", busyCnt, WORDS);
        checkOutput("small sum", sum, 64'd1014);
        checkOutput("small cout", cout, 0);
        collectResult();
        checkOutput("small sum held", sum, 64'd1014);

        // Every slice boundary carries; result held under backpressure while in_valid is ignored.
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0);
        waitResult(lat, busyCnt);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 64'(i * 7 + 3); b = 64'(i); cin = 1'b1;
            @(posedge clk); #1;
            checkOutput("bp sum", sum, 64'h1111_1111_1111_1100);
            checkOutput("bp cout", cout, 1);
            checkOutput("bp in_ready", in_ready, 0);
            checkOutput("bp out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        collectResult();

        // Asynchronous abort mid-run; partially written slices must not survive.
        applyStimulus(64'h0001_0000_0000_FFFF, 64'd1, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", in_ready, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort sum", sum, 64'd0);
        checkOutput("abort cout", cout, 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(64'd5, 64'd0, 1'b0);
        waitResult(lat, busyCnt);
        checkOutput("fresh sum", sum, 64'd5);
        checkOutput("fresh cout", cout, 0);
        collectResult();

`ifdef CSA_SEQ_OVF_EN
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        waitResult(lat, busyCnt);
        checkOutput("ovf sum", sum, 64'h8000_0000_0000_0000);
        checkOutput("ovf cout", cout, 0);
        checkOutput("ovf flag", ovf, 1);
        collectResult();
`endif

        @(posedge clk); @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
